router_west_psum_buf: RTL and testbench

//  West-edge psum router, buffered successor to the combinational west router. Forwards NUM_LANES-wide psum

---
 rtl/router_west_psum_buf_if.sv | 59 +++++
 rtl/router_west_psum_buf.sv | 168 ++++++++++++++++
 tb/tb_router_west_psum_buf.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/router_west_psum_buf_if.sv
// rtl/router_west_psum_buf_if.sv - handshake/bus bundle for router_west_psum_buf
// ROUTER_PSUM_PERF_EN adds the two perf counter outputs.
interface router_west_psum_buf_if #(
  parameter int unsigned DATA_BITWIDTH     = 16,
  parameter int unsigned NUM_LANES         = 5,
  parameter int unsigned ADDR_BITWIDTH_GLB = 10
);
  localparam int unsigned W = DATA_BITWIDTH * NUM_LANES;

  logic                         cfg_valid_i;
  logic [3:0]                   cfg_mode_i;
  logic                         cfg_ready_o;
  logic                         north_valid_i;
  logic [W-1:0]                 north_data_i;
  logic                         north_ready_o;
  logic                         west_valid_i;
  logic [W-1:0]                 west_data_i;
  logic                         west_ready_o;
  logic                         south_valid_o;
  logic [W-1:0]                 south_data_o;
  logic                         south_ready_i;
  logic                         east_valid_o;
  logic [W-1:0]                 east_data_o;
  logic                         east_ready_i;
  logic                         spad_valid_i;
  logic [W-1:0]                 spad_data_i;
  logic                         spad_ready_o;
  logic                         addr_clr_i;
  logic                         glb_we_o;
  logic [ADDR_BITWIDTH_GLB-1:0] glb_addr_o;
  logic [DATA_BITWIDTH-1:0]     glb_data_o;
  logic                         drain_done_o;
`ifdef ROUTER_PSUM_PERF_EN
  logic [31:0]                  perf_fwd_cnt_o;
  logic [31:0]                  perf_stall_cnt_o;
`endif

  modport slave (
    input  cfg_valid_i, cfg_mode_i, north_valid_i, north_data_i, west_valid_i, west_data_i,
           south_ready_i, east_ready_i, spad_valid_i, spad_data_i, addr_clr_i,
    output cfg_ready_o, north_ready_o, west_ready_o, south_valid_o, south_data_o,
           east_valid_o, east_data_o, spad_ready_o, glb_we_o, glb_addr_o, glb_data_o,
`ifdef ROUTER_PSUM_PERF_EN
           perf_fwd_cnt_o, perf_stall_cnt_o,
`endif
           drain_done_o
  );

  modport master (
    output cfg_valid_i, cfg_mode_i, north_valid_i, north_data_i, west_valid_i, west_data_i,
           south_ready_i, east_ready_i, spad_valid_i, spad_data_i, addr_clr_i,
    input  cfg_ready_o, north_ready_o, west_ready_o, south_valid_o, south_data_o,
           east_valid_o, east_data_o, spad_ready_o, glb_we_o, glb_addr_o, glb_data_o,
`ifdef ROUTER_PSUM_PERF_EN
           perf_fwd_cnt_o, perf_stall_cnt_o,
`endif
           drain_done_o
  );
endinterface

// File: rtl/router_west_psum_buf.sv
// rtl/router_west_psum_buf.sv - buffered west-edge psum router and PE-row to GLB serialiser
// ROUTER_PSUM_PERF_EN adds saturating forward/stall counters.
module router_west_psum_buf #(
  parameter int unsigned DATA_BITWIDTH     = 16,
  parameter int unsigned NUM_LANES         = 5,
  parameter int unsigned ADDR_BITWIDTH_GLB = 10,
  parameter int unsigned PSUM_BASE_ADDR    = 0,
  parameter int unsigned PSUM_DEPTH        = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  router_west_psum_buf_if.slave  bus
);
  localparam int unsigned W      = DATA_BITWIDTH * NUM_LANES;
  localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);
  localparam logic [ADDR_BITWIDTH_GLB-1:0] BASE_ADDR = ADDR_BITWIDTH_GLB'(PSUM_BASE_ADDR);
  localparam logic [ADDR_BITWIDTH_GLB-1:0] LAST_ADDR =
    ADDR_BITWIDTH_GLB'(PSUM_BASE_ADDR + PSUM_DEPTH - 1);

  localparam logic [3:0] MODE_SOUTH     = 4'd2;
  localparam logic [3:0] MODE_EAST      = 4'd4;
  localparam logic [3:0] MODE_EASTSOUTH = 4'd6;
  localparam logic [3:0] MODE_CLOSED    = 4'd11;

  typedef enum logic [0:0] {SER_IDLE = 1'b0, SER_DRAIN = 1'b1} ser_state_e;

  logic [3:0]                   mode_q, mode_d;
  logic [1:0]                   pend_q, pend_d;      // bit0 = south, bit1 = east
  logic [W-1:0]                 fwd_data_q, fwd_data_d;
  ser_state_e                   ser_state_q, ser_state_d;
  logic [LANE_W-1:0]            lane_q, lane_d;
  logic [W-1:0]                 vec_q, vec_d;
  logic [ADDR_BITWIDTH_GLB-1:0] addr_q, addr_d;

  logic [1:0]               mode_mask;
  logic [1:0]               hs;
  logic [1:0]               pend_left;
  logic                     can_accept;
  logic                     north_rdy;
  logic                     west_rdy;
  logic                     load;
  logic                     cfg_rdy;
  logic                     draining;
  logic                     last_lane;
  logic                     spad_rdy;
  logic                     spad_acc;
  logic [DATA_BITWIDTH-1:0] lane_word;

  // Forwarding stage: a destination drops its pending bit on its own handshake,
  // and a new vector may load in the same cycle the last pending bit drops.
  always_comb begin
    mode_mask = 2'b00;
    case (mode_q)
      MODE_SOUTH:     mode_mask = 2'b01;
      MODE_EAST:      mode_mask = 2'b10;
      MODE_EASTSOUTH: mode_mask = 2'b11;
      default:        mode_mask = 2'b00;
    endcase
    hs         = pend_q & {bus.east_ready_i, bus.south_ready_i};
    pend_left  = pend_q & ~hs;
    can_accept = (pend_left == 2'b00) && (mode_mask != 2'b00);
    north_rdy  = can_accept && bus.north_valid_i;
    west_rdy   = can_accept && !bus.north_valid_i;
    load       = north_rdy || (west_rdy && bus.west_valid_i);
    pend_d     = load ? mode_mask : pend_left;
    fwd_data_d = fwd_data_q;
    if (load) begin
      fwd_data_d = bus.north_valid_i ? bus.north_data_i : bus.west_data_i;
    end
    cfg_rdy = (pend_q == 2'b00) && (ser_state_q == SER_IDLE);
    mode_d  = (bus.cfg_valid_i && cfg_rdy) ? bus.cfg_mode_i : mode_q;
  end

  always_comb begin
    draining  = (ser_state_q == SER_DRAIN);
    last_lane = draining && (lane_q == LAST_LANE);
    spad_rdy  = !draining || last_lane;
    spad_acc  = bus.spad_valid_i && spad_rdy;
    lane_word = '0;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      if (lane_q == LANE_W'(i)) begin
        lane_word = vec_q[i*DATA_BITWIDTH +: DATA_BITWIDTH];
      end
    end
    ser_state_d = ser_state_q;
    lane_d      = lane_q;
    vec_d       = vec_q;
    if (spad_acc) begin
      ser_state_d = SER_DRAIN;
      lane_d      = '0;
      vec_d       = bus.spad_data_i;
    end else if (last_lane) begin
      ser_state_d = SER_IDLE;
    end else if (draining) begin
      lane_d = lane_q + 1'b1;
    end
    // Clear wins over increment; the write this cycle still uses addr_q.
    addr_d = addr_q;
    if (bus.addr_clr_i) begin
      addr_d = BASE_ADDR;
    end else if (draining) begin
      addr_d = (addr_q == LAST_ADDR) ? BASE_ADDR : addr_q + 1'b1;
    end
  end

`ifdef ROUTER_PSUM_PERF_EN
  logic [31:0] perf_fwd_q, perf_fwd_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fwd_d   = perf_fwd_q;
    perf_stall_d = perf_stall_q;
    if (load && (perf_fwd_q != 32'hFFFF_FFFF)) begin
      perf_fwd_d = perf_fwd_q + 32'd1;
    end
    if ((pend_q != 2'b00) && (hs == 2'b00) && (perf_stall_q != 32'hFFFF_FFFF)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fwd_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fwd_q   <= perf_fwd_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign bus.perf_fwd_cnt_o   = perf_fwd_q;
  assign bus.perf_stall_cnt_o = perf_stall_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q      <= MODE_CLOSED;
      pend_q      <= 2'b00;
      fwd_data_q  <= '0;
      ser_state_q <= SER_IDLE;
      lane_q      <= '0;
      vec_q       <= '0;
      addr_q      <= BASE_ADDR;
    end else begin
      mode_q      <= mode_d;
      pend_q      <= pend_d;
      fwd_data_q  <= fwd_data_d;
      ser_state_q <= ser_state_d;
      lane_q      <= lane_d;
      vec_q       <= vec_d;
      addr_q      <= addr_d;
    end
  end

  assign bus.cfg_ready_o   = cfg_rdy;
  assign bus.north_ready_o = north_rdy;
  assign bus.west_ready_o  = west_rdy;
  assign bus.south_valid_o = pend_q[0];
  assign bus.east_valid_o  = pend_q[1];
  assign bus.south_data_o  = fwd_data_q;
  assign bus.east_data_o   = fwd_data_q;
  assign bus.spad_ready_o  = spad_rdy;
  assign bus.glb_we_o      = draining;
  assign bus.glb_addr_o    = addr_q;
  assign bus.glb_data_o    = draining ? lane_word : '0;
  assign bus.drain_done_o  = last_lane;
endmodule

// File: tb/tb_router_west_psum_buf.sv
// tb/tb_router_west_psum_buf.sv - randomized bench for router_west_psum_buf against a queue-based model
module tb_router_west_psum_buf;
  localparam int DB    = 16;
  localparam int NL    = 5;
  localparam int AW    = 10;
  localparam int BASE  = 0;
  localparam int DEPTH = 8;
  localparam int W     = DB * NL;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  router_west_psum_buf_if #(.DATA_BITWIDTH(DB), .NUM_LANES(NL), .ADDR_BITWIDTH_GLB(AW)) bus ();

  router_west_psum_buf #(
    .DATA_BITWIDTH(DB), .NUM_LANES(NL), .ADDR_BITWIDTH_GLB(AW),
    .PSUM_BASE_ADDR(BASE), .PSUM_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [W-1:0] data;
    bit           s;
    bit           e;
  } fwd_item_t;

  typedef struct {
    logic [DB-1:0] word;
    bit            last;
  } wr_item_t;

  fwd_item_t   fq[$];
  wr_item_t    wq[$];
  int          maddr;
  logic [3:0]  mmode;
  int unsigned mfwd;
  int unsigned mstall;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] dest_mask(input logic [3:0] code);
    case (code)
      4'd2:    return 2'b01;
      4'd4:    return 2'b10;
      4'd6:    return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_reset();
    fq.delete();
    wq.delete();
    maddr  = BASE;
    mmode  = 4'd11;
    mfwd   = 0;
    mstall = 0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_south_valid"}, bus.south_valid_o, 1'b0);
    check({tag, "_east_valid"}, bus.east_valid_o, 1'b0);
    check({tag, "_south_data"}, bus.south_data_o, '0);
    check({tag, "_east_data"}, bus.east_data_o, '0);
    check({tag, "_glb_we"}, bus.glb_we_o, 1'b0);
    check({tag, "_glb_addr"}, bus.glb_addr_o, BASE);
    check({tag, "_glb_data"}, bus.glb_data_o, '0);
    check({tag, "_drain_done"}, bus.drain_done_o, 1'b0);
`ifdef ROUTER_PSUM_PERF_EN
    check({tag, "_perf_fwd"}, bus.perf_fwd_cnt_o, 0);
    check({tag, "_perf_stall"}, bus.perf_stall_cnt_o, 0);
`endif
  endtask

  task automatic drive_idle();
    bus.cfg_valid_i   = 1'b0;
    bus.cfg_mode_i    = 4'd0;
    bus.north_valid_i = 1'b0;
    bus.north_data_i  = '0;
    bus.west_valid_i  = 1'b0;
    bus.west_data_i   = '0;
    bus.south_ready_i = 1'b0;
    bus.east_ready_i  = 1'b0;
    bus.spad_valid_i  = 1'b0;
    bus.spad_data_i   = '0;
    bus.addr_clr_i    = 1'b0;
  endtask

  task automatic drive_random(input int cyc);
    logic [95:0] r;
    logic [3:0]  codes[4];
    int          rthr;
    codes = '{4'd2, 4'd4, 4'd6, 4'd11};
    rthr  = 1 + ((cyc / 150) % 3);
    bus.north_valid_i = ($urandom_range(0, 2) == 0);
    r = {$urandom(), $urandom(), $urandom()};
    bus.north_data_i  = r[W-1:0];
    bus.west_valid_i  = ($urandom_range(0, 2) != 0);
    r = {$urandom(), $urandom(), $urandom()};
    bus.west_data_i   = r[W-1:0];
    bus.south_ready_i = ($urandom_range(0, 3) < rthr);
    bus.east_ready_i  = ($urandom_range(0, 3) < rthr);
    bus.spad_valid_i  = ($urandom_range(0, 3) < rthr);
    r = {$urandom(), $urandom(), $urandom()};
    bus.spad_data_i   = r[W-1:0];
    bus.addr_clr_i    = ($urandom_range(0, 39) == 0);
    bus.cfg_valid_i   = ($urandom_range(0, 7) == 0);
    if ($urandom_range(0, 4) == 4) bus.cfg_mode_i = 4'($urandom_range(0, 15));
    else bus.cfg_mode_i = codes[$urandom_range(0, 3)];
  endtask

  task automatic step_check();
    logic [1:0]   mask;
    logic [W-1:0] v;
    fwd_item_t    h;
    wr_item_t     wi;
    bit sv, ev, hs_s, hs_e, frees, can, enr, ewr, ecr, esr, accept, load, stall, ewe;
    mask = dest_mask(mmode);
    sv = (fq.size() > 0) && fq[0].s;
    ev = (fq.size() > 0) && fq[0].e;
    check("south_valid", bus.south_valid_o, sv);
    check("east_valid", bus.east_valid_o, ev);
    if (sv) check("south_data", bus.south_data_o, fq[0].data);
    if (ev) check("east_data", bus.east_data_o, fq[0].data);
    hs_s  = sv && bus.south_ready_i;
    hs_e  = ev && bus.east_ready_i;
    frees = (fq.size() == 0) || ((sv == hs_s) && (ev == hs_e));
    can   = frees && (mask != 2'b00);
    enr   = can && bus.north_valid_i;
    ewr   = can && !bus.north_valid_i;
    check("north_ready", bus.north_ready_o, enr);
    check("west_ready", bus.west_ready_o, ewr);
    ecr = (fq.size() == 0) && (wq.size() == 0);
    check("cfg_ready", bus.cfg_ready_o, ecr);
    ewe = (wq.size() > 0);
    check("glb_we", bus.glb_we_o, ewe);
    if (ewe) begin
      check("glb_addr", bus.glb_addr_o, maddr);
      check("glb_data", bus.glb_data_o, wq[0].word);
      check("drain_done", bus.drain_done_o, wq[0].last);
    end else begin
      check("drain_done_idle", bus.drain_done_o, 1'b0);
    end
    esr = (wq.size() <= 1);
    check("spad_ready", bus.spad_ready_o, esr);
`ifdef ROUTER_PSUM_PERF_EN
    check("perf_fwd", bus.perf_fwd_cnt_o, mfwd);
    check("perf_stall", bus.perf_stall_cnt_o, mstall);
`endif
    accept = bus.spad_valid_i && esr;
    load   = enr || (ewr && bus.west_valid_i);
    stall  = (fq.size() > 0) && !hs_s && !hs_e;
    if (fq.size() > 0) begin
      if (frees) begin
        void'(fq.pop_front());
      end else begin
        h = fq[0];
        h.s = h.s && !hs_s;
        h.e = h.e && !hs_e;
        fq[0] = h;
      end
    end
    if (load) begin
      h.data = bus.north_valid_i ? bus.north_data_i : bus.west_data_i;
      h.s    = mask[0];
      h.e    = mask[1];
      fq.push_back(h);
    end
    if (ewe) void'(wq.pop_front());
    if (bus.addr_clr_i) maddr = BASE;
    else if (ewe) maddr = (maddr == BASE + DEPTH - 1) ? BASE : maddr + 1;
    if (accept) begin
      v = bus.spad_data_i;
      for (int i = 0; i < NL; i++) begin
        wi.word = v[i*DB +: DB];
        wi.last = (i == NL - 1);
        wq.push_back(wi);
      end
    end
    if (bus.cfg_valid_i && ecr) mmode = bus.cfg_mode_i;
    if (load && mfwd != 32'hFFFF_FFFF) mfwd++;
    if (stall && mstall != 32'hFFFF_FFFF) mstall++;
  endtask

  initial begin
    drive_idle();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    check("reset_spad_ready", bus.spad_ready_o, 1'b1);
    check("reset_cfg_ready", bus.cfg_ready_o, 1'b1);
    check("reset_north_ready", bus.north_ready_o, 1'b0);
    reset = 1'b1;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      @(posedge clk);
      #1;
      drive_random(cyc);
      if (cyc == 400 || cyc == 850) begin
        #1 reset = 1'b0;
        #1 check_reset("midrst");
        model_reset();
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
      end else begin
        @(negedge clk);
        step_check();
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
